// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Purpose : Types shared by the N-channel stream multiplexer and its
//           round-robin arbiter.
// Contents: mux_mode_t -- MODE_FIXED selects the channel given by sel,
//                         MODE_RR rotates among the channels that are valid.
// -----------------------------------------------------------------------------
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

endpackage : stream_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purpose : Round-robin arbiter. It grants the first requesting channel,
//           searching upward from ptr+1 and wrapping modulo N_CH. It owns the
//           priority pointer, which moves to the granted channel only when the
//           caller signals that the grant was actually used.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset (ptr -> N_CH-1)
//           req        per-channel request (in_valid)
//           advance    grant consumed this cycle; ptr <= grant_idx
//           grant_idx  index of the granted channel
//           grant_vld  a grant exists (at least one request)
// -----------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [SW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  // Walk the offsets from farthest to nearest so that the channel closest
  // to ptr+1 is the last one written and therefore wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld) begin
      ptr_d = grant_idx;
    end
  end

  // Reset value N_CH-1 makes channel 0 the first candidate after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SW'(N_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
// Purpose : N-channel valid/ready stream multiplexer with a one-word output
//           register. The source channel is chosen either by sel (MODE_FIXED)
//           or by a round-robin arbiter (MODE_RR). Full throughput: a new word
//           is accepted in the same cycle the held word leaves.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           mode       0 = MODE_FIXED, 1 = MODE_RR
//           sel        channel select for MODE_FIXED
//           in_valid   per-channel valid
//           in_data    flattened channel data, channel i at [i*W +: W]
//           in_ready   per-channel ready (one-hot or zero)
//           out_valid  output register holds a word
//           out_ready  downstream accepts the word
//           out_data   registered data
//           out_ch     channel that supplied out_data
// -----------------------------------------------------------------------------
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch
);

  mux_mode_t     mode_e;
  logic [W-1:0]  ch_data [N_CH];

  logic          fix_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic          load;
  logic          take;
  logic          rr_advance;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;

  assign mode_e = mux_mode_t'(mode);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign in_ready[gi] = take && (gnt_idx == SW'(gi));
    end
  endgenerate

  // sel can exceed N_CH-1 when N_CH is not a power of two; such a value
  // never produces a grant.
  assign fix_vld = (int'(sel) < N_CH) && in_valid[sel];

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (rr_advance),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode_e == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else if (fix_vld) begin
      gnt_vld = 1'b1;
      gnt_idx = sel;
    end
  end

  // The output register can take a word when empty or when its word leaves
  // in this same cycle.
  assign load       = !out_valid_q || out_ready;
  assign take       = load && gnt_vld;
  // ptr only follows grants that were really transferred in round-robin mode.
  assign rr_advance = take && (mode_e == MODE_RR);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gnt_idx];
      out_ch_d    = gnt_idx;
    end else if (load) begin
      // Word drained (or register already empty) with nothing to refill it;
      // data and channel keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule : stream_mux_n
